// File: rtl/disp_hex_mux_sync_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
// Imported by the slot timer and by the top-level scan controller.
package disp_hex_mux_sync_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_SHOW = 2'd2
    } disp_state_e;

    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [7:0] SSEG_OFF = 8'hFF;

    // Active-low anode pattern for one digit, or all-dark when that digit is blanked.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx, input logic blank);
        logic [3:0] sel;
        if (blank) begin
            sel = AN_OFF;
        end else begin
            sel = ~(4'b0001 << idx);
        end
        return sel;
    endfunction

endpackage

// File: rtl/disp_hex_mux_sync_slot_timer.sv
// Free-running digit-slot counter: q counts every cycle and wraps at 2**PRESC_W-1,
// with wrap flagging the last cycle of the slot.
module disp_hex_mux_sync_slot_timer
    import disp_hex_mux_sync_pkg::*;
#(
    parameter int PRESC_W = 18
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [PRESC_W-1:0] q,
    output logic               wrap
);

    localparam logic [PRESC_W-1:0] Q_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] Q_MAX = {PRESC_W{1'b1}};

    logic [PRESC_W-1:0] q_d;
    logic [PRESC_W-1:0] q_q;

    // Next count; natural binary overflow provides the wrap to zero.
    always_comb begin
        q_d = q_q + Q_ONE;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= {PRESC_W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign wrap = (q_q == Q_MAX);

endmodule

// File: rtl/disp_hex_mux_sync.sv
// Four-digit multiplexed seven-segment scanner in front of a registered hex-to-segment ROM.
// Each slot loads the ROM address, stays dark while the ROM settles, then captures and lights.
module disp_hex_mux_sync
    import disp_hex_mux_sync_pkg::*;
#(
    parameter int PRESC_W   = 18,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic [1:0]  digit_idx
);

    localparam logic [PRESC_W-1:0] CAPTURE_Q = PRESC_W'(BLANK_CYC);

    logic [PRESC_W-1:0] q_s;
    logic               wrap_s;
    logic [1:0]         digit_next_s;
    logic               unused_rom_msb_s;

    disp_state_e state_d, state_q;
    logic [1:0]  digit_idx_d, digit_idx_q;
    logic [3:0]  rom_addr_d, rom_addr_q;
    logic        dp_l_d, dp_l_q;
    logic        blank_l_d, blank_l_q;
    logic [3:0]  an_d, an_q;
    logic [7:0]  sseg_d, sseg_q;

    disp_hex_mux_sync_slot_timer #(
        .PRESC_W (PRESC_W)
    ) u_slot_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (q_s),
        .wrap    (wrap_s)
    );

    assign digit_next_s     = digit_idx_q + 2'd1;
    assign unused_rom_msb_s = rom_data[7];

    // Scan FSM: load address and flags, wait out ROM latency dark, then show until the slot wraps.
    always_comb begin
        state_d     = state_q;
        digit_idx_d = digit_idx_q;
        rom_addr_d  = rom_addr_q;
        dp_l_d      = dp_l_q;
        blank_l_d   = blank_l_q;
        an_d        = an_q;
        sseg_d      = sseg_q;
        case (state_q)
            ST_LOAD: begin
                digit_idx_d = digit_next_s;
                rom_addr_d  = hex_in[{digit_next_s, 2'b00} +: 4];
                dp_l_d      = dp_in[digit_next_s];
                blank_l_d   = blank_in[digit_next_s];
                an_d        = AN_OFF;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // The ROM registered the address at least one edge ago, so its data is settled here.
                if (q_s == CAPTURE_Q) begin
                    sseg_d  = {~dp_l_q, rom_data[6:0]};
                    an_d    = anode_sel(digit_idx_q, blank_l_q);
                    state_d = ST_SHOW;
                end else begin
                    an_d    = AN_OFF;
                end
            end
            ST_SHOW: begin
                if (wrap_s) begin
                    an_d    = AN_OFF;
                    state_d = ST_LOAD;
                end else begin
                    an_d    = an_q;
                end
            end
            default: begin
                an_d    = AN_OFF;
                state_d = ST_LOAD;
            end
        endcase
    end

    // State, index, ROM address and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            digit_idx_q <= 2'd3;
            rom_addr_q  <= 4'h0;
            dp_l_q      <= 1'b0;
            blank_l_q   <= 1'b0;
            an_q        <= AN_OFF;
            sseg_q      <= SSEG_OFF;
        end else begin
            state_q     <= state_d;
            digit_idx_q <= digit_idx_d;
            rom_addr_q  <= rom_addr_d;
            dp_l_q      <= dp_l_d;
            blank_l_q   <= blank_l_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign an        = an_q;
    assign sseg      = sseg_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_disp_hex_mux_sync.sv
// Bench for disp_hex_mux_sync with a registered hex-to-segment ROM attached and a 16-cycle slot.
// A slot-arithmetic model is compared every cycle; directed literal checks pin the model.
module tb_disp_hex_mux_sync;

    localparam int PW   = 4;
    localparam int BC   = 2;
    localparam int SLOT = 16;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b1;
    logic [15:0] hex_in   = 16'h0000;
    logic [3:0]  dp_in    = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [1:0]  digit_idx;

    int checks   = 0;
    int failures = 0;

    disp_hex_mux_sync #(.PRESC_W(PW), .BLANK_CYC(BC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hex_in    (hex_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .an        (an),
        .sseg      (sseg),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    // Synchronous ROM; bit 7 held 0 so a design that passes it through shows up on sseg[7].
    always @(posedge clk) rom_data <= {1'b0, seg7(rom_addr)};

    // Model: k_m = rising edges since reset release; per-slot inputs latched at the slot's first edge.
    int         k_m       = 0;
    logic [3:0] hex_l_m   = 4'h0;
    logic       dp_l_m    = 1'b0;
    logic       blank_l_m = 1'b0;
    logic [7:0] sseg_m    = 8'hFF;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_m <= 0; hex_l_m <= 4'h0; dp_l_m <= 1'b0; blank_l_m <= 1'b0; sseg_m <= 8'hFF;
        end else begin
            k_m <= k_m + 1;
            if (k_m % SLOT == 0) begin
                hex_l_m   <= hex_in[4*((k_m/SLOT)%4) +: 4];
                dp_l_m    <= dp_in[(k_m/SLOT)%4];
                blank_l_m <= blank_in[(k_m/SLOT)%4];
            end
            if (k_m % SLOT == BC) sseg_m <= {~dp_l_m, seg7(hex_l_m)};
        end
    end

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] v, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (an !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmp(nm, {4'h0, an}, {4'h0, v});
    endtask

    task automatic compare_model();
        int         d;
        logic [3:0] exp_an;
        d      = (k_m == 0) ? 3 : ((k_m - 1) / SLOT) % 4;
        exp_an = (k_m % SLOT >= BC + 1 && !blank_l_m) ? ~(4'b0001 << d) : 4'b1111;
        cmp("model_an", {4'h0, an}, {4'h0, exp_an});
        cmp("model_sseg", sseg, sseg_m);
        cmp("model_rom_addr", {4'h0, rom_addr}, {4'h0, hex_l_m});
        cmp("model_digit_idx", {6'h00, digit_idx}, 8'(d));
        cmp_int("one_anode_max", ($countones(~an) > 1) ? 1 : 0, 0);
    endtask

    initial begin
        int dark;
        int lit3;
        int n;
        fork
            forever begin
                @(negedge clk);
                compare_model();
            end
        join_none

        // 1: reset held with toggling inputs
        reset_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            hex_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
            cmp("rst_an", {4'h0, an}, 8'h0F);
            cmp("rst_sseg", sseg, 8'hFF);
            cmp("rst_rom_addr", {4'h0, rom_addr}, 8'h00);
        end
        hex_in = 16'h3210; dp_in = 4'h0; blank_in = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;

        // 2: basic scan order and patterns
        wait_an(4'b1110, "first_lit_an");  cmp("d0_sseg", sseg, 8'h81);
        wait_an(4'b1101, "d1_an");         cmp("d1_sseg", sseg, 8'hCF);
        wait_an(4'b1011, "d2_an");         cmp("d2_sseg", sseg, 8'h92);
        wait_an(4'b0111, "d3_an");         cmp("d3_sseg", sseg, 8'h86);

        // 3: three dark cycles in every 16-cycle slot
        dark = 0;
        repeat (64) begin
            @(negedge clk);
            if (an == 4'b1111) dark++;
        end
        cmp_int("dark_per_round", dark, 12);

        // 4: decimal point on digit 2, digit 3 blanked
        @(negedge clk);
        dp_in = 4'b0100; blank_in = 4'b1000;
        wait_an(4'b1110, "t4_d0_an");
        wait_an(4'b1011, "t4_d2_an");
        cmp("t4_d2_dp_sseg", sseg, 8'h12);
        lit3 = 0;
        repeat (64) begin
            @(negedge clk);
            if (an == 4'b0111) lit3++;
        end
        cmp_int("t4_d3_never_lit", lit3, 0);

        // 5: digit 0 value change mid-slot shows only on its next slot
        @(negedge clk);
        dp_in = 4'h0; blank_in = 4'h0;
        wait_an(4'b1110, "t5_d0_an");
        @(negedge clk);
        hex_in = 16'h321F;
        repeat (10) @(negedge clk);
        cmp("t5_hold_an", {4'h0, an}, 8'h0E);
        cmp("t5_hold_sseg", sseg, 8'h81);
        wait_an(4'b1101, "t5_d1_an");
        wait_an(4'b1110, "t5_next_d0_an");
        cmp("t5_new_sseg", sseg, 8'hB8);

        // 6: asynchronous reset in the middle of digit 2's lit phase
        wait_an(4'b1011, "t6_d2_an");
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        cmp("t6_async_an", {4'h0, an}, 8'h0F);
        cmp("t6_async_sseg", sseg, 8'hFF);
        cmp("t6_async_digit", {6'h00, digit_idx}, 8'h03);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        @(negedge clk);
        while (an === 4'b1111 && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmp("t6_restart_an", {4'h0, an}, 8'h0E);
        cmp("t6_restart_sseg", sseg, 8'hB8);

        repeat (40) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
